// File: rtl/isr_pkg.sv
// Shared encodings for the interrupt entry/exit sequencer: FSM states, exit-step
// one-hot codes and the default ISR entry address.
package isr_pkg;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StSync    = 4'd1,
        StFlush   = 4'd2,
        StPush    = 4'd3,
        StVector  = 4'd4,
        StService = 4'd5,
        StL0      = 4'd6,
        StL1      = 4'd7,
        StL2      = 4'd8,
        StResume  = 4'd9
    } isr_state_e;

    // Exit pop steps, in the order they are issued.
    localparam logic [2:0] LISR_POP_PC = 3'b001;
    localparam logic [2:0] LISR_POP_ST = 3'b010;
    localparam logic [2:0] LISR_SP     = 3'b100;

    localparam logic [31:0] VEC_ADDR_DEFAULT = 32'h0000_0180;

endpackage

// File: rtl/int_sync.sv
// Multi-stage synchronizer for the asynchronous interrupt line, followed by a
// rising-edge detector that emits a one-cycle pulse.
module int_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign pulse = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/isr_sequencer.sv
// Interrupt entry/exit sequencer for the 5-stage pipeline: owns Flush/Stall while
// pushing or popping context, and forwards the hazard/branch requests otherwise.
module isr_sequencer
    import isr_pkg::*;
#(
    parameter logic [31:0] VEC_ADDR    = VEC_ADDR_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        intr,
    input  logic        int_en,
    input  logic        hazard_stall,
    input  logic        flush_req,
    input  logic        reti,
    output logic        Flush,
    output logic        Stall,
    output logic        ISR,
    output logic [2:0]  LISR,
    output logic        pc_sel_vec,
    output logic        pc_hold,
    output logic [31:0] vec_addr,
    output logic        in_service,
    output logic        int_ack
);

    isr_state_e state_q, state_d;
    logic       pend_q;
    logic       intr_edge;

    logic       flush_q, isr_q, vec_q, hold_q, svc_q, pass_q;
    logic [2:0] lisr_q;

    int_sync #(
        .STAGES(SYNC_STAGES)
    ) u_int_sync (
        .clk     (clk),
        .rst     (rst),
        .async_in(intr),
        .pulse   (intr_edge)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (pend_q && int_en) state_d = StSync;
            StSync:    if (!hazard_stall && !flush_req) state_d = StFlush;
            StFlush:   state_d = StPush;
            StPush:    state_d = StVector;
            StVector:  state_d = StService;
            StService: if (reti && !hazard_stall) state_d = StL0;
            StL0:      state_d = StL1;
            StL1:      state_d = StL2;
            StL2:      state_d = StResume;
            StResume:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs are registered decodes of the state being entered, so they line up
    // with state_q and reset to zero together with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            pend_q  <= 1'b0;
            flush_q <= 1'b0;
            isr_q   <= 1'b0;
            vec_q   <= 1'b0;
            hold_q  <= 1'b0;
            svc_q   <= 1'b0;
            pass_q  <= 1'b0;
            lisr_q  <= '0;
        end else begin
            state_q <= state_d;
            // Edges arriving before PUSH merge into the request being served.
            if (state_q == StPush) begin
                pend_q <= 1'b0;
            end else if (intr_edge) begin
                pend_q <= 1'b1;
            end
            flush_q <= state_d inside {StFlush, StResume};
            isr_q   <= (state_d == StPush);
            vec_q   <= (state_d == StVector);
            hold_q  <= state_d inside {StFlush, StPush, StL0, StL1, StL2};
            svc_q   <= state_d inside {StVector, StService, StL0, StL1, StL2};
            pass_q  <= state_d inside {StIdle, StSync, StService};
            case (state_d)
                StL0:    lisr_q <= LISR_POP_PC;
                StL1:    lisr_q <= LISR_POP_ST;
                StL2:    lisr_q <= LISR_SP;
                default: lisr_q <= '0;
            endcase
        end
    end

    assign Flush      = flush_q | (pass_q & flush_req);
    assign Stall      = pass_q & hazard_stall;
    assign ISR        = isr_q;
    assign int_ack    = isr_q;
    assign LISR       = lisr_q;
    assign pc_sel_vec = vec_q;
    assign pc_hold    = hold_q;
    assign in_service = svc_q;
    assign vec_addr   = VEC_ADDR;

endmodule

// File: tb/tb_isr_sequencer.sv
// Randomized bench for isr_sequencer: a script-based reference model predicts every
// cycle's outputs into a queue that a negedge monitor drains and compares.
module tb_isr_sequencer;

    localparam logic [31:0] VEC = 32'h0000_0180;
    localparam int          SS  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        intr = 1'b0, int_en = 1'b0, hazard_stall = 1'b0, flush_req = 1'b0;
    logic        reti = 1'b0;
    logic        Flush, Stall, ISR, pc_sel_vec, pc_hold, in_service, int_ack;
    logic [2:0]  LISR;
    logic [31:0] vec_addr;

    always #5 clk = ~clk;

    isr_sequencer #(
        .VEC_ADDR   (VEC),
        .SYNC_STAGES(SS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .intr        (intr),
        .int_en      (int_en),
        .hazard_stall(hazard_stall),
        .flush_req   (flush_req),
        .reti        (reti),
        .Flush       (Flush),
        .Stall       (Stall),
        .ISR         (ISR),
        .LISR        (LISR),
        .pc_sel_vec  (pc_sel_vec),
        .pc_hold     (pc_hold),
        .vec_addr    (vec_addr),
        .in_service  (in_service),
        .int_ack     (int_ack)
    );

    typedef struct packed {
        logic        flush, stall, isr;
        logic [2:0]  lisr;
        logic        vec, hold, svc, ack;
        logic [31:0] addr;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0, errors = 0;
    int   acks_expected = 0, acks_seen = 0;

    // Reference model: phases plus a script of fixed cycles the sequencer owns.
    localparam int PIdle = 0, PWait = 1, PScript = 2, PService = 3;
    int   phase, after_phase;
    obs_t script[$];
    bit   m_pend, m_fresh;
    bit   dly[$];  // intr samples, newest first

    function automatic obs_t mk(bit f, bit i, logic [2:0] l, bit v, bit h, bit s);
        obs_t o;
        o = '0;
        o.flush = f; o.isr = i; o.ack = i; o.lisr = l;
        o.vec = v; o.hold = h; o.svc = s; o.addr = VEC;
        return o;
    endfunction

    task automatic model_reset();
        phase = PIdle;
        after_phase = PIdle;
        script.delete();
        m_pend = 1'b0;
        dly.delete();
        for (int i = 0; i <= SS; i++) dly.push_back(1'b0);
    endtask

    task automatic model_step();
        bit edge_seen, clr;
        if (!rst) begin
            model_reset();
            m_fresh = 1'b1;
            return;
        end
        m_fresh   = 1'b0;
        edge_seen = dly[SS-1] && !dly[SS];
        clr       = (phase == PScript) && script[0].isr;
        case (phase)
            PIdle: if (m_pend && int_en) phase = PWait;
            PWait: if (!hazard_stall && !flush_req) begin
                script = '{mk(1, 0, 3'b000, 0, 1, 0), mk(0, 1, 3'b000, 0, 1, 0),
                           mk(0, 0, 3'b000, 1, 0, 1)};
                phase = PScript;
                after_phase = PService;
            end
            PScript: begin
                void'(script.pop_front());
                if (script.size() == 0) phase = after_phase;
            end
            PService: if (reti && !hazard_stall) begin
                script = '{mk(0, 0, 3'b001, 0, 1, 1), mk(0, 0, 3'b010, 0, 1, 1),
                           mk(0, 0, 3'b100, 0, 1, 1), mk(1, 0, 3'b000, 0, 0, 0)};
                phase = PScript;
                after_phase = PIdle;
            end
            default: phase = PIdle;
        endcase
        if (clr) m_pend = 1'b0;
        else if (edge_seen) m_pend = 1'b1;
        dly.push_front(intr);
        void'(dly.pop_back());
    endtask

    function automatic obs_t model_out();
        obs_t o;
        o = '0;
        o.addr = VEC;
        if (!rst || m_fresh) return o;
        if (phase == PScript) return script[0];
        o.flush = flush_req;
        o.stall = hazard_stall;
        o.svc   = (phase == PService);
        return o;
    endfunction

    // Monitor: one prediction per cycle, compared away from the active edge.
    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {Flush, Stall, ISR, LISR, pc_sel_vec, pc_hold, in_service, int_ack, vec_addr};
            if (int_ack === 1'b1) acks_seen++;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t actual=%h required=%h", $time, a, e);
            end
        end
    end

    int p_tog, p_hs, p_fr, p_reti, p_en_flip, rst_hold;
    bit arm_l1_reset;

    initial begin
        obs_t e;
        model_reset();
        m_fresh = 1'b1;
        rst_hold = 2;
        for (int seg = 0; seg < 6; seg++) begin
            arm_l1_reset = 1'b0;
            p_en_flip = 0;
            int_en = 1'b1;
            case (seg)
                0: begin p_tog = 10; p_hs = 0;  p_fr = 0;  p_reti = 5;  end
                1: begin p_tog = 10; p_hs = 40; p_fr = 30; p_reti = 10; end
                2: begin p_tog = 12; p_hs = 10; p_fr = 10; p_reti = 15;
                         p_en_flip = 3; int_en = 1'b0; end
                3: begin p_tog = 35; p_hs = 15; p_fr = 15; p_reti = 3;  end
                4: begin p_tog = 15; p_hs = 10; p_fr = 10; p_reti = 25;
                         arm_l1_reset = 1'b1; end
                default: begin p_tog = 20; p_hs = 25; p_fr = 25; p_reti = 20;
                               p_en_flip = 5; end
            endcase
            for (int c = 0; c < 400; c++) begin
                @(posedge clk);
                model_step();
                #1;
                if (rst_hold > 0) begin
                    rst = 1'b0;
                    rst_hold--;
                end else if (arm_l1_reset && phase == PScript && script[0].lisr == 3'b010
                             && $urandom_range(1) == 1) begin
                    rst = 1'b0;
                    rst_hold = 1;
                end else begin
                    rst = 1'b1;
                end
                if ($urandom_range(99) < p_tog) intr = ~intr;
                if ($urandom_range(99) < p_en_flip) int_en = ~int_en;
                hazard_stall = ($urandom_range(99) < p_hs);
                flush_req    = ($urandom_range(99) < p_fr);
                reti         = ($urandom_range(99) < p_reti);
                e = model_out();
                if (e.ack) acks_expected++;
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        checks++;
        if (acks_seen != acks_expected) begin
            errors++;
            $display("FAIL ack_count actual=%0d required=%0d", acks_seen, acks_expected);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
